// File: rtl/delayed_value_checker_pkg.sv
// Shared state encoding and default parameters for delayed_value_checker.
package delayed_value_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_DELAY         = 15;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_MAX_MISMATCH  = 3;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/delayed_value_checker_sat_counter.sv
// Up-counter with clear and increment; with sat high it sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(sat && count == MAX_V)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/delayed_value_checker.sv
// Waits DELAY edges after start, then requires STABLE_CYCLES consecutive matches before MAX_MISMATCH misses.
// Optional X/Z detection on value is enabled by defining DELAYED_VALUE_CHECKER_XCHECK_EN.
//
// state | meaning
// IDLE  | no check run since reset
// WAIT  | counting down to the first compare edge
// CHECK | comparing value against the held expected value every edge
// DONE  | result held on pass/fail/mismatch_cnt until the next start
module delayed_value_checker
  import delayed_value_checker_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DELAY         = DEF_DELAY,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_MISMATCH  = DEF_MAX_MISMATCH,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             x_seen
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  state_t           state;
  logic [CNT_W-1:0] delay_cnt;
  logic [WIDTH-1:0] exp_q;
  logic [SW-1:0]    stable_cnt;
  logic             go, in_check, xbad, match, stable_hit, miss_hit;

  assign go       = start && (state == IDLE || state == DONE);
  assign in_check = (state == CHECK);

`ifdef DELAYED_VALUE_CHECKER_XCHECK_EN
  assign xbad = ((^value) === 1'bx);
`else
  assign xbad = 1'b0;
`endif

  // Only a definite 1 from the equality counts as a match; unknown samples are misses.
  assign match      = ((value == exp_q) === 1'b1) && !xbad;
  assign stable_hit = match && (stable_cnt == SW'(STABLE_CYCLES - 1));
  assign miss_hit   = (mismatch_cnt == CNT_W'(MAX_MISMATCH - 1));

  sat_counter #(.W(SW), .MAX(STABLE_CYCLES)) u_stable (
    .clk   (clk),
    .rst   (rst),
    .clr   (go || (in_check && !match)),
    .inc   (in_check && match),
    .sat   (1'b1),
    .count (stable_cnt)
  );

  sat_counter #(.W(CNT_W), .MAX(MAX_MISMATCH)) u_mismatch (
    .clk   (clk),
    .rst   (rst),
    .clr   (go),
    .inc   (in_check && !match),
    .sat   (1'b1),
    .count (mismatch_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      delay_cnt <= '0;
      exp_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      x_seen    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            exp_q     <= expected;
            delay_cnt <= CNT_W'(DELAY - 1);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            x_seen    <= 1'b0;
            // A one-edge delay makes the very next edge a compare edge.
            state     <= (DELAY == 1) ? CHECK : WAIT;
          end
        end
        WAIT: begin
          if (delay_cnt == CNT_W'(1)) begin
            state <= CHECK;
          end else begin
            delay_cnt <= delay_cnt - CNT_W'(1);
          end
        end
        CHECK: begin
          if (xbad) begin
            x_seen <= 1'b1;
            fail   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (stable_hit) begin
            pass  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (!match && miss_hit) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delayed_value_checker.sv
// Bench for delayed_value_checker: per-edge stimulus tables replayed against a check-level reference model.
module tb_delayed_value_checker;

  localparam int N  = 64;
  localparam int D  = 15;
  localparam int ST = 4;
  localparam int MM = 3;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] value, expected;
  logic       busy, done, pass, fail, x_seen;
  logic [7:0] mismatch_cnt;

  int checks   = 0;
  int failures = 0;

  logic       st_a [N];
  logic       rs_a [N];
  logic [3:0] vq   [N];
  logic [3:0] ex   [N];

  logic       o_busy [N], o_done [N], o_pass [N], o_fail [N], o_xs [N];
  logic [7:0] o_mm   [N];
  logic [12:0] m_tup [N];

  delayed_value_checker dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .value        (value),
    .expected     (expected),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .mismatch_cnt (mismatch_cnt),
    .x_seen       (x_seen)
  );

  always #5 clk = ~clk;

  task automatic clear_stim(input logic [3:0] v, input logic [3:0] e);
    for (int j = 0; j < N; j++) begin
      st_a[j] = 1'b0;
      rs_a[j] = 1'b0;
      vq[j]   = v;
      ex[j]   = e;
    end
  endtask

  // Reset for one cycle, then replay edges 0..n-1 and record outputs 1 time unit after each edge.
  task automatic run(input int n);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < n; j++) begin
      start = st_a[j]; rst = rs_a[j]; value = vq[j]; expected = ex[j];
      @(posedge clk); #1;
      o_busy[j] = busy; o_done[j] = done; o_pass[j] = pass;
      o_fail[j] = fail; o_xs[j] = x_seen; o_mm[j] = mismatch_cnt;
    end
    rst = 1'b0; start = 1'b0;
  endtask

  // Reference: a check started at edge s compares on edges s+D onward, ending on the
  // ST-th consecutive match or the MM-th miss; starts are only accepted with no check running.
  task automatic model(input int n);
    bit act, dn, ps, fl, xs, xv;
    int s, run_len, mm;
    logic [3:0] hold;
    act = 0; dn = 0; ps = 0; fl = 0; xs = 0; s = 0; run_len = 0; mm = 0; hold = '0;
    for (int j = 0; j < n; j++) begin
      if (rs_a[j]) begin
        act = 0; dn = 0; ps = 0; fl = 0; xs = 0; mm = 0; run_len = 0; hold = '0;
      end else if (act) begin
        if (j - s >= D) begin
`ifdef DELAYED_VALUE_CHECKER_XCHECK_EN
          xv = ((^vq[j]) === 1'bx);
`else
          xv = 1'b0;
`endif
          if (xv) begin
            if (mm < MM) mm++;
            fl = 1; xs = 1; act = 0; dn = 1;
          end else if ((vq[j] == hold) === 1'b1) begin
            run_len++;
            if (run_len == ST) begin ps = 1; act = 0; dn = 1; end
          end else begin
            run_len = 0;
            if (mm < MM) mm++;
            if (mm == MM) begin fl = 1; act = 0; dn = 1; end
          end
        end
      end else if (st_a[j]) begin
        act = 1; s = j; hold = ex[j]; run_len = 0; mm = 0;
        dn = 0; ps = 0; fl = 0; xs = 0;
      end
      m_tup[j] = {act, dn, ps, fl, xs, 8'(mm)};
    end
  endtask

  task automatic compare_all(input int n, input string tag);
    logic [12:0] got;
    for (int j = 0; j < n; j++) begin
      got = {o_busy[j], o_done[j], o_pass[j], o_fail[j], o_xs[j], o_mm[j]};
      checks++;
      if (got !== m_tup[j]) begin
        failures++;
        $display("FAIL %s edge=%0d {busy,done,pass,fail,x_seen,mm} got=%h want=%h", tag, j, got, m_tup[j]);
      end
    end
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; value = 4'h5; expected = 4'h5;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, fail, x_seen, mismatch_cnt} !== 13'h0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {busy, done, pass, fail, x_seen, mismatch_cnt});
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_pass();
    clear_stim(4'h5, 4'h5); st_a[0] = 1'b1;
    run(25); model(25); compare_all(25, "pass_seq");
    expect_bit("pass_busy_e17", o_busy[17], 1'b1);
    expect_bit("pass_busy_e18", o_busy[18], 1'b0);
    expect_bit("pass_e17", o_pass[17], 1'b0);
    expect_bit("pass_e18", o_pass[18] & o_done[18], 1'b1);
    expect_bit("pass_mm0", o_mm[18] == 8'd0, 1'b1);
  endtask

  task automatic test_fail();
    clear_stim(4'h3, 4'h5); st_a[0] = 1'b1;
    run(25); model(25); compare_all(25, "fail_seq");
    expect_bit("fail_e16", o_done[16], 1'b0);
    expect_bit("fail_e17", o_fail[17] & o_done[17] & ~o_pass[17], 1'b1);
    expect_bit("fail_mm3", o_mm[17] == 8'd3, 1'b1);
  endtask

  task automatic test_glitch();
    clear_stim(4'h5, 4'h5); st_a[0] = 1'b1; vq[17] = 4'h3;
    run(28); model(28); compare_all(28, "glitch_seq");
    expect_bit("glitch_e20", o_pass[20], 1'b0);
    expect_bit("glitch_e21", o_pass[21], 1'b1);
    expect_bit("glitch_mm1", o_mm[21] == 8'd1, 1'b1);
  endtask

  task automatic test_reset_mid();
    clear_stim(4'h5, 4'h5);
    for (int j = 0; j <= 7; j++) st_a[j] = 1'b1;
    rs_a[7] = 1'b1; st_a[9] = 1'b1;
    run(32); model(32); compare_all(32, "rst_mid_seq");
    expect_bit("rst_mid_e7_idle",
               o_busy[7] | o_done[7] | o_pass[7] | o_fail[7] | o_xs[7] | (|o_mm[7]), 1'b0);
    expect_bit("rst_mid_e26", o_pass[26], 1'b0);
    expect_bit("rst_mid_e27", o_pass[27], 1'b1);
  endtask

  task automatic test_back_to_back();
    clear_stim(4'h5, 4'h5);
    st_a[0] = 1'b1; st_a[5] = 1'b1; st_a[16] = 1'b1; st_a[20] = 1'b1;
    run(45); model(45); compare_all(45, "b2b_seq");
    expect_bit("b2b_e18", o_pass[18], 1'b1);
    expect_bit("b2b_e20_clear", o_pass[20] | o_done[20], 1'b0);
    expect_bit("b2b_e37", o_pass[37], 1'b0);
    expect_bit("b2b_e38", o_pass[38], 1'b1);
  endtask

  task automatic test_expected_change();
    clear_stim(4'h5, 4'h9); ex[0] = 4'h5; st_a[0] = 1'b1;
    run(25); model(25); compare_all(25, "exp_hold_seq");
    expect_bit("exp_hold_e18", o_pass[18], 1'b1);
  endtask

  task automatic test_xvalue();
    bit xv;
    clear_stim(4'h5, 4'h5); st_a[0] = 1'b1; vq[15] = 4'bx1x1;
    xv = $isunknown(vq[15]);
    run(25); model(25); compare_all(25, "xval_seq");
`ifdef DELAYED_VALUE_CHECKER_XCHECK_EN
    if (xv) begin
      expect_bit("xval_fail_e15", o_fail[15] & o_xs[15], 1'b1);
    end else begin
      expect_bit("xval_pass_e18", o_pass[18] & ~o_xs[18], 1'b1);
    end
`else
    if (xv) begin
      expect_bit("xval_pass_e19", o_pass[19] & ~o_pass[18] & ~o_xs[19], 1'b1);
      expect_bit("xval_mm1", o_mm[19] == 8'd1, 1'b1);
    end else begin
      expect_bit("xval_pass_e18", o_pass[18] & ~o_xs[18], 1'b1);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] base;
    for (int it = 0; it < 6; it++) begin
      base = 4'($urandom);
      clear_stim(base, base);
      for (int j = 0; j < N; j++) begin
        vq[j]   = ($urandom_range(0, 4) != 0) ? base : 4'($urandom);
        ex[j]   = ($urandom_range(0, 3) != 0) ? base : 4'($urandom);
        st_a[j] = ($urandom_range(0, 7) == 0);
        rs_a[j] = ($urandom_range(0, 49) == 0);
      end
      st_a[0] = 1'b1; ex[0] = base; rs_a[0] = 1'b0;
      run(N); model(N); compare_all(N, "random_seq");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; value = '0; expected = '0;
    test_reset();
    test_pass();
    test_fail();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_expected_change();
    test_xvalue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
